// File: rtl/lcd_frame_capture.sv
// LCD frame grabber: syncs to vblank, stores a LINES x LINEWIDTH frame of
// 2-bit shade codes and exposes it through a registered random-access read port.
module lcd_frame_capture #(
  parameter int LINEWIDTH = 160,
  parameter int LINES     = 144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture_en,
  input  logic        pixel_valid,
  input  logic [1:0]  pixel,
  input  logic        hblank,
  input  logic        vblank,
  input  logic        err_clear,
  input  logic [7:0]  rd_y,
  input  logic [7:0]  rd_x,
  output logic [1:0]  rd_data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        line_error
);

  localparam int XW    = $clog2(LINEWIDTH + 1);
  localparam int YW    = $clog2(LINES + 1);
  localparam int DEPTH = LINES * LINEWIDTH;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [XW-1:0] X_END = XW'(LINEWIDTH);
  localparam logic [YW-1:0] Y_END = YW'(LINES);

  typedef enum logic [1:0] {IDLE, SYNC, CAPTURE} state_t;

  state_t          state, state_nxt;
  logic [XW-1:0]   x, x_nxt, x_adv;
  logic [YW-1:0]   y, y_nxt, y_adv;
  logic            done_nxt;
  logic [15:0]     count_nxt;
  logic            err_set;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;
  logic            rd_in_range;

  logic [1:0] mem [DEPTH];

  assign busy = (state != IDLE);

  // Within one cycle the order is pixel write, then line advance, then frame check.
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    x_adv     = x;
    y_adv     = y;
    done_nxt  = 1'b0;
    count_nxt = frame_count;
    err_set   = 1'b0;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (capture_en) state_nxt = SYNC;
      end
      SYNC: begin
        if (!capture_en) begin
          state_nxt = IDLE;
        end else if (vblank) begin
          state_nxt = CAPTURE;
          x_nxt     = '0;
          y_nxt     = '0;
        end
      end
      CAPTURE: begin
        if (pixel_valid) begin
          if (x < X_END && y < Y_END) begin
            wr_en = 1'b1;
            x_adv = x + XW'(1);
          end else begin
            err_set = 1'b1;
          end
        end
        if (hblank) begin
          if (x_adv != X_END) err_set = 1'b1;
          x_adv = '0;
          if (y < Y_END) y_adv = y + YW'(1);
        end
        x_nxt = x_adv;
        y_nxt = y_adv;
        if (vblank) begin
          if (y_adv != Y_END) err_set = 1'b1;
          done_nxt  = 1'b1;
          count_nxt = frame_count + 16'd1;
          x_nxt     = '0;
          y_nxt     = '0;
          if (!capture_en) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_addr     = AW'(32'(y) * 32'(LINEWIDTH) + 32'(x));
  assign rd_addr     = AW'(32'(rd_y) * 32'(LINEWIDTH) + 32'(rd_x));
  assign rd_in_range = (32'(rd_y) < 32'(LINES)) && (32'(rd_x) < 32'(LINEWIDTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
      line_error  <= 1'b0;
    end else begin
      state       <= state_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      frame_done  <= done_nxt;
      frame_count <= count_nxt;
      // A fresh error in the same cycle as err_clear keeps the flag set.
      line_error  <= err_set | (line_error & ~err_clear);
    end
  end

  // Frame buffer is never reset; reads see pre-write contents on collision.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= pixel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= 2'b00;
    else       rd_data <= rd_in_range ? mem[rd_addr] : 2'b00;
  end

endmodule

// File: tb/tb_lcd_frame_capture.sv
// Directed bench for lcd_frame_capture: clean frame, geometry errors,
// mode control and mid-frame reset, all with hand-computed expectations.
module tb_lcd_frame_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        capture_en;
  logic        pixel_valid;
  logic [1:0]  pixel;
  logic        hblank;
  logic        vblank;
  logic        err_clear;
  logic [7:0]  rd_y;
  logic [7:0]  rd_x;
  logic [1:0]  rd_data;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        line_error;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lcd_frame_capture dut (
    .clk         (clk),
    .reset       (reset),
    .capture_en  (capture_en),
    .pixel_valid (pixel_valid),
    .pixel       (pixel),
    .hblank      (hblank),
    .vblank      (vblank),
    .err_clear   (err_clear),
    .rd_y        (rd_y),
    .rd_x        (rd_x),
    .rd_data     (rd_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .line_error  (line_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pixels(input int y, input int n, input int off, input bit hb_last);
    for (int x = 0; x < n; x++) begin
      pixel_valid = 1'b1;
      pixel       = 2'((x + y + off) % 4);
      hblank      = hb_last && (x == n - 1);
      tick();
    end
    pixel_valid = 1'b0;
    hblank      = 1'b0;
  endtask

  task automatic end_line(input bit vb);
    hblank = 1'b1;
    vblank = vb;
    tick();
    hblank = 1'b0;
    vblank = 1'b0;
  endtask

  task automatic check_px(input string tag, input int y, input int x, input logic [1:0] exp);
    rd_y = 8'(y);
    rd_x = 8'(x);
    tick();
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; capture_en = 1'b0; pixel_valid = 1'b0; pixel = 2'd0;
    hblank = 1'b0; vblank = 1'b0; err_clear = 1'b0; rd_y = 8'd0; rd_x = 8'd0;
    tick(); tick();
    check("rst_busy",   32'(busy), 0);
    check("rst_done",   32'(frame_done), 0);
    check("rst_count",  32'(frame_count), 0);
    check("rst_err",    32'(line_error), 0);
    check("rst_rdata",  32'(rd_data), 0);
    reset = 1'b0;
    tick();

    // SYNC: pixels and hblank must be ignored; dropping capture_en returns to IDLE
    capture_en = 1'b1;
    tick();
    check("sync_busy", 32'(busy), 1);
    pixel_valid = 1'b1; pixel = 2'd3; hblank = 1'b1;
    tick();
    pixel_valid = 1'b0; hblank = 1'b0;
    check("sync_ignore_err", 32'(line_error), 0);
    check("sync_still_busy", 32'(busy), 1);
    capture_en = 1'b0;
    tick();
    check("sync_to_idle", 32'(busy), 0);
    capture_en = 1'b1;
    tick();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;

    // Frame A: clean frame, pattern (x+y)%4
    drive_pixels(0, 160, 0, 1'b1);
    check("coll_px_hb_err", 32'(line_error), 0);
    for (int y = 1; y < 143; y++) begin
      drive_pixels(y, 160, 0, 1'b0);
      end_line(1'b0);
    end
    drive_pixels(143, 160, 0, 1'b0);
    end_line(1'b1);
    check("a_done",  32'(frame_done), 1);
    check("a_count", 32'(frame_count), 1);
    check("a_err",   32'(line_error), 0);
    check("a_busy",  32'(busy), 1);
    tick();
    check("a_done_pulse", 32'(frame_done), 0);
    check_px("a_px_10_20",   10, 20, 2'd2);
    check_px("a_px_0_159",   0, 159, 2'd3);
    check_px("a_px_143_159", 143, 159, 2'd2);

    // Frame B: pattern (x+y+1)%4, overflow on line 0, short line 5, capture_en dropped
    drive_pixels(0, 160, 1, 1'b0);
    pixel_valid = 1'b1; pixel = 2'd3; err_clear = 1'b1;
    tick();
    pixel_valid = 1'b0; err_clear = 1'b0;
    check("ovf_err_wins", 32'(line_error), 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("ovf_err_clear", 32'(line_error), 0);
    end_line(1'b0);
    check("ovf_hblank_ok", 32'(line_error), 0);
    for (int y = 1; y < 5; y++) begin
      drive_pixels(y, 160, 1, 1'b0);
      end_line(1'b0);
    end
    drive_pixels(5, 159, 1, 1'b0);
    end_line(1'b0);
    check("short_err", 32'(line_error), 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("short_clear", 32'(line_error), 0);
    for (int y = 6; y < 144; y++) begin
      if (y == 100) capture_en = 1'b0;
      drive_pixels(y, 160, 1, 1'b0);
      end_line(1'b0);
    end
    check("drop_still_busy", 32'(busy), 1);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    check("b_done",  32'(frame_done), 1);
    check("b_count", 32'(frame_count), 2);
    check("b_err",   32'(line_error), 0);
    check("b_idle",  32'(busy), 0);
    tick();
    check("b_done_pulse", 32'(frame_done), 0);
    check_px("ovf_px_0_159",   0, 159, 2'd0);
    check_px("short_px_5_157", 5, 157, 2'd3);
    check_px("short_px_5_159", 5, 159, 2'd0);
    check_px("l6_px_0",        6, 0,   2'd3);
    check_px("l6_px_159",      6, 159, 2'd2);

    // Frame C: reset partway through line 70
    capture_en = 1'b1;
    tick();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    for (int y = 0; y < 70; y++) begin
      drive_pixels(y, 160, 0, 1'b0);
      end_line(1'b0);
    end
    drive_pixels(70, 50, 0, 1'b0);
    reset = 1'b1;
    #1;
    check("mrst_busy",  32'(busy), 0);
    check("mrst_count", 32'(frame_count), 0);
    check("mrst_done",  32'(frame_done), 0);
    check("mrst_err",   32'(line_error), 0);
    check("mrst_rdata", 32'(rd_data), 0);
    tick();
    reset = 1'b0;
    tick();
    check("mrst_sync", 32'(busy), 1);
    drive_pixels(70, 110, 50, 1'b1);
    check("mrst_sync_err",  32'(line_error), 0);
    check("mrst_sync_done", 32'(frame_done), 0);
    capture_en = 1'b0;
    tick();
    check("mrst_idle", 32'(busy), 0);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    check("idle_vb_done",  32'(frame_done), 0);
    check("idle_vb_count", 32'(frame_count), 0);
    check_px("oor_144_0",  144, 0,  2'd0);
    check_px("c_px_10_20", 10, 20,  2'd2);
    check_px("c_px_69_5",  69, 5,   2'd2);
    check_px("c_px_70_10", 70, 10,  2'd0);
    check_px("c_px_70_100", 70, 100, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
